// File: rtl/sha_pkg.sv
// Shared definitions for the SHA message front-end: padder states,
// block/length geometry for the SHA-2 family and a strobe popcount.
package sha_pkg;

  // Padder control states.
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT      = 2'd1,
    EXTRA     = 2'd2,
    EMIT_LAST = 2'd3
  } sha_pad_state_e;

  // Marker byte that follows the last message byte.
  localparam logic [7:0] ShaPadByte = 8'h80;

  // SHA-1 / SHA-256 geometry.
  localparam int Sha256BlockWidth = 512;
  localparam int Sha256LenWidth   = 64;

  // SHA-384 / SHA-512 geometry.
  localparam int Sha512BlockWidth = 1024;
  localparam int Sha512LenWidth   = 128;

  // Number of set bits in a byte-lane strobe (up to 16 lanes).
  function automatic int unsigned popcount(input logic [15:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sha_stream_padder.sv
// Byte-stream to SHA block packer with Merkle-Damgard padding.
// Words are packed big-endian into a block buffer; the final beat gets a
// 0x80 marker, zero fill and the message bit length in the low bits of the
// final block. A second, padding-only block is produced when the marker or
// the length does not fit behind the message bytes.
module sha_stream_padder
  import sha_pkg::*;
#(
  parameter int DataWidth  = 64,
  parameter int BlockWidth = Sha256BlockWidth,
  parameter int LenWidth   = Sha256LenWidth,
  parameter int DataBytes  = DataWidth >> 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DataWidth-1:0]  data_i,
  input  logic [DataBytes-1:0]  strobe_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic                  ready_o,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  output logic                  last_block_o,
  input  logic                  block_ready_i,
  output logic                  err_o
);

  localparam int WordsPerBlock = BlockWidth / DataWidth;
  localparam int BlockBytes    = BlockWidth / 8;
  // First byte of the length field inside a block.
  localparam int LenOffset     = (BlockWidth - LenWidth) / 8;
  localparam int PtrWidth      = $clog2(WordsPerBlock);
  // Byte positions must be able to express "one past the block end".
  localparam int PosWidth      = $clog2(BlockBytes) + 1;
  localparam int CntWidth      = $clog2(DataBytes) + 1;

  // Architectural state.
  sha_pad_state_e        state_reg, state_next;
  logic [BlockWidth-1:0] buf_reg, buf_next;
  logic [PtrWidth-1:0]   ptr_reg, ptr_next;
  logic [LenWidth-1:0]   len_reg, len_next;
  logic                  err_reg, err_next;
  // A padding-only block is still owed after the current EMIT.
  logic                  extra_reg, extra_next;
  // That padding-only block must start with the 0x80 marker.
  logic                  pad80_reg, pad80_next;
  // Holds ready_o low for the first cycle after reset.
  logic                  active_reg;

  // Beat decode.
  logic [CntWidth-1:0]   strobe_count;
  logic [DataBytes-1:0]  strobe_mask;
  logic                  strobe_contig;
  logic                  strobe_full;
  logic [CntWidth-1:0]   keep_bytes;
  logic [PosWidth-1:0]   pad_pos;
  logic [LenWidth-1:0]   len_total;
  logic                  accept;

  // Buffer write controls shared by all byte lanes.
  logic                  clear_buf;
  logic                  write_word;
  logic                  write_pad;
  logic                  write_len;
  logic [PosWidth-1:0]   pad_sel;
  logic [LenWidth-1:0]   len_field;

  assign ready_o       = active_reg && (state_reg == FILL);
  assign block_valid_o = (state_reg == EMIT) || (state_reg == EMIT_LAST);
  assign last_block_o  = (state_reg == EMIT_LAST);
  assign block_o       = buf_reg;
  assign err_o         = err_reg;

  assign accept        = ready_o && valid_i;

  // A legal strobe is popcount ones packed against the MSB lane.
  assign strobe_count  = CntWidth'(popcount(16'(strobe_i)));
  assign strobe_mask   = ~({DataBytes{1'b1}} >> strobe_count);
  assign strobe_contig = (strobe_i == strobe_mask);
  assign strobe_full   = &strobe_i;

  // Non-last beats always count as full words, even if the strobe was bad.
  assign keep_bytes    = last_i ? strobe_count : CntWidth'(DataBytes);

  // Byte index just past the valid bytes of this beat = message bytes in block.
  assign pad_pos       = PosWidth'(ptr_reg) * PosWidth'(DataBytes) + PosWidth'(keep_bytes);
  assign len_total     = len_reg + (LenWidth'(keep_bytes) << 3);

  // Next-state, pointer, length and buffer-write control.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    len_next   = len_reg;
    err_next   = err_reg;
    extra_next = extra_reg;
    pad80_next = pad80_reg;
    clear_buf  = 1'b0;
    write_word = 1'b0;
    write_pad  = 1'b0;
    write_len  = 1'b0;
    pad_sel    = pad_pos;
    len_field  = len_total;

    unique case (state_reg)
      FILL: begin
        if (accept) begin
          write_word = 1'b1;
          ptr_next   = ptr_reg + 1'b1;
          len_next   = len_total;
          if (!strobe_contig || (!last_i && !strobe_full)) begin
            err_next = 1'b1;
          end
          if (last_i) begin
            if (pad_pos == PosWidth'(BlockBytes)) begin
              // Message ends exactly on the block boundary: the marker
              // moves into a padding-only block.
              extra_next = 1'b1;
              pad80_next = 1'b1;
              state_next = EMIT;
            end else begin
              write_pad = 1'b1;
              if (pad_pos < PosWidth'(LenOffset)) begin
                write_len  = 1'b1;
                state_next = EMIT_LAST;
              end else begin
                extra_next = 1'b1;
                pad80_next = 1'b0;
                state_next = EMIT;
              end
            end
          end else if (ptr_reg == PtrWidth'(WordsPerBlock - 1)) begin
            state_next = EMIT;
          end
        end
      end

      EMIT: begin
        if (block_ready_i) begin
          clear_buf  = 1'b1;
          ptr_next   = '0;
          state_next = extra_reg ? EXTRA : FILL;
        end
      end

      EXTRA: begin
        // Buffer is already zero; add the optional marker and the length.
        pad_sel    = '0;
        len_field  = len_reg;
        write_pad  = pad80_reg;
        write_len  = 1'b1;
        extra_next = 1'b0;
        pad80_next = 1'b0;
        state_next = EMIT_LAST;
      end

      EMIT_LAST: begin
        if (block_ready_i) begin
          clear_buf  = 1'b1;
          ptr_next   = '0;
          len_next   = '0;
          state_next = FILL;
        end
      end

      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Per-byte-lane insertion: data byte, marker or length byte.
  for (genvar gi = 0; gi < BlockBytes; gi++) begin : g_lane
    localparam int  Word  = gi / DataBytes;
    localparam int  Lane  = gi % DataBytes;
    localparam int  Hi    = BlockWidth - 1 - 8 * gi;
    localparam bit  IsLen = (gi >= LenOffset);

    logic [7:0] len_byte;
    logic [7:0] lane_next;

    if (IsLen) begin : g_len
      assign len_byte = len_field[LenWidth - 1 - 8 * (gi - LenOffset) -: 8];
    end else begin : g_no_len
      assign len_byte = 8'h00;
    end

    // Later writes win: marker over zero fill, nothing overlaps the length.
    always_comb begin
      lane_next = buf_reg[Hi -: 8];
      if (clear_buf) begin
        lane_next = 8'h00;
      end
      if (write_word && (ptr_reg == PtrWidth'(Word))) begin
        lane_next = (CntWidth'(Lane) < keep_bytes) ?
                    data_i[DataWidth - 1 - 8 * Lane -: 8] : 8'h00;
      end
      if (write_pad && (pad_sel == PosWidth'(gi))) begin
        lane_next = ShaPadByte;
      end
      if (write_len && IsLen) begin
        lane_next = len_byte;
      end
    end

    assign buf_next[Hi -: 8] = lane_next;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= FILL;
      buf_reg    <= '0;
      ptr_reg    <= '0;
      len_reg    <= '0;
      err_reg    <= 1'b0;
      extra_reg  <= 1'b0;
      pad80_reg  <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      buf_reg    <= buf_next;
      ptr_reg    <= ptr_next;
      len_reg    <= len_next;
      err_reg    <= err_next;
      extra_reg  <= extra_next;
      pad80_reg  <= pad80_next;
      active_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha_stream_padder.sv
// Directed bench for sha_stream_padder: three instances cover 32-bit and
// 64-bit words with 512-bit blocks, and 64-bit words with 1024-bit blocks.
module tb_sha_stream_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: 32-bit words, 512-bit blocks.
  logic         a_rst, a_valid, a_last, a_ready, a_bv, a_lb, a_bready, a_err;
  logic [31:0]  a_data;
  logic [3:0]   a_strobe;
  logic [511:0] a_block;

  // Instance B: 64-bit words, 512-bit blocks.
  logic         b_rst, b_valid, b_last, b_ready, b_bv, b_lb, b_bready, b_err;
  logic [63:0]  b_data;
  logic [7:0]   b_strobe;
  logic [511:0] b_block;

  // Instance C: 64-bit words, 1024-bit blocks, 128-bit length.
  logic          c_rst, c_valid, c_last, c_ready, c_bv, c_lb, c_bready, c_err;
  logic [63:0]   c_data;
  logic [7:0]    c_strobe;
  logic [1023:0] c_block;

  sha_stream_padder #(.DataWidth(32), .BlockWidth(512), .LenWidth(64)) u_a (
    .clk_i(clk), .rst_i(a_rst), .data_i(a_data), .strobe_i(a_strobe),
    .valid_i(a_valid), .last_i(a_last), .ready_o(a_ready), .block_o(a_block),
    .block_valid_o(a_bv), .last_block_o(a_lb), .block_ready_i(a_bready),
    .err_o(a_err)
  );

  sha_stream_padder #(.DataWidth(64), .BlockWidth(512), .LenWidth(64)) u_b (
    .clk_i(clk), .rst_i(b_rst), .data_i(b_data), .strobe_i(b_strobe),
    .valid_i(b_valid), .last_i(b_last), .ready_o(b_ready), .block_o(b_block),
    .block_valid_o(b_bv), .last_block_o(b_lb), .block_ready_i(b_bready),
    .err_o(b_err)
  );

  sha_stream_padder #(.DataWidth(64), .BlockWidth(1024), .LenWidth(128)) u_c (
    .clk_i(clk), .rst_i(c_rst), .data_i(c_data), .strobe_i(c_strobe),
    .valid_i(c_valid), .last_i(c_last), .ready_o(c_ready), .block_o(c_block),
    .block_valid_o(c_bv), .last_block_o(c_lb), .block_ready_i(c_bready),
    .err_o(c_err)
  );

  logic [511:0]  exp_abc32;
  logic [511:0]  exp_b;
  logic [1023:0] exp_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word on A and hold it until accepted.
  task automatic a_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int guard;
    guard = 0;
    a_data = d; a_strobe = s; a_last = l; a_valid = 1'b1;
    while (!a_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!a_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL a_send_timeout: ready=%b required 1", a_ready);
    end
    tick();
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic b_send(input logic [63:0] d, input logic [7:0] s, input logic l);
    int guard;
    guard = 0;
    b_data = d; b_strobe = s; b_last = l; b_valid = 1'b1;
    while (!b_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!b_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL b_send_timeout: ready=%b required 1", b_ready);
    end
    tick();
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  // Message of nbytes bytes with values 1,2,3,...; unused lanes carry 0xEE.
  task automatic b_send_msg(input int nbytes);
    int nwords;
    nwords = (nbytes + 7) / 8;
    for (int w = 0; w < nwords; w++) begin
      logic [63:0] d;
      logic [7:0]  s;
      int          k;
      k = nbytes - 8 * w;
      if (k > 8) k = 8;
      s = 8'hFF;
      s = s << (8 - k);
      for (int j = 0; j < 8; j++) begin
        d[63 - 8 * j -: 8] = (8 * w + j < nbytes) ? 8'(8 * w + j + 1) : 8'hEE;
      end
      b_send(d, s, (w == nwords - 1));
    end
  endtask

  function automatic logic [511:0] msg_image(input int nbytes);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < nbytes && i < 64; i++) begin
      v[511 - 8 * i -: 8] = 8'(i + 1);
    end
    return v;
  endfunction

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_valid = 0; a_last = 0; a_data = '0; a_strobe = '0; a_bready = 0;
    b_valid = 0; b_last = 0; b_data = '0; b_strobe = '0; b_bready = 0;
    c_valid = 0; c_last = 0; c_data = '0; c_strobe = '0; c_bready = 0;
    tick();
    tick();
    tests_run++;
    if ({a_ready, a_bv, a_lb, a_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_a_flags: got %b expected 0000", {a_ready, a_bv, a_lb, a_err});
    end
    tests_run++;
    if (a_block !== 512'd0) begin
      tests_failed++;
      $display("FAIL reset_a_block: got %h expected 0", a_block);
    end
    tests_run++;
    if ({b_ready, b_bv, b_lb, b_err, c_ready, c_bv, c_lb, c_err} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_bc_flags: got %b expected 00000000",
               {b_ready, b_bv, b_lb, b_err, c_ready, c_bv, c_lb, c_err});
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();
    tests_run++;
    if ({a_ready, b_ready, c_ready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 111", {a_ready, b_ready, c_ready});
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_abc_32();
    exp_abc32 = '0;
    exp_abc32[511:480] = 32'h61626380;
    exp_abc32[63:0]    = 64'h18;
    a_send(32'h61626300, 4'b1110, 1'b1);
    tests_run++;
    if ({a_bv, a_lb, a_ready} !== 3'b110) begin
      tests_failed++;
      $display("FAIL abc32_flags: got bv/lb/ready=%b expected 110", {a_bv, a_lb, a_ready});
    end
    tests_run++;
    if (a_block !== exp_abc32) begin
      tests_failed++;
      $display("FAIL abc32_block: got %h expected %h", a_block, exp_abc32);
    end
    a_bready = 1'b1;
    tick();
    a_bready = 1'b0;
    tests_run++;
    if ({a_bv, a_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL abc32_after_handshake: got bv/ready=%b expected 01", {a_bv, a_ready});
    end
    $display("[TB] abc 32-bit block checked");
  endtask

  task automatic test_empty();
    logic [511:0] e;
    e = '0;
    e[511:504] = 8'h80;
    a_send(32'h0, 4'b0000, 1'b1);
    tests_run++;
    if ({a_bv, a_lb} !== 2'b11) begin
      tests_failed++;
      $display("FAIL empty_flags: got bv/lb=%b expected 11", {a_bv, a_lb});
    end
    tests_run++;
    if (a_block !== e) begin
      tests_failed++;
      $display("FAIL empty_block: got %h expected %h", a_block, e);
    end
    a_bready = 1'b1;
    tick();
    a_bready = 1'b0;
    $display("[TB] empty message checked");
  endtask

  task automatic test_55_bytes();
    exp_b = msg_image(55);
    exp_b[511 - 8 * 55 -: 8] = 8'h80;
    exp_b[63:0] = 64'h1B8;
    b_send_msg(55);
    tests_run++;
    if ({b_bv, b_lb} !== 2'b11) begin
      tests_failed++;
      $display("FAIL len55_flags: got bv/lb=%b expected 11", {b_bv, b_lb});
    end
    tests_run++;
    if (b_block !== exp_b) begin
      tests_failed++;
      $display("FAIL len55_block: got %h expected %h", b_block, exp_b);
    end
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    $display("[TB] 55-byte message checked");
  endtask

  task automatic test_56_bytes();
    exp_b = msg_image(56);
    exp_b[511 - 8 * 56 -: 8] = 8'h80;
    b_send_msg(56);
    tests_run++;
    if ({b_bv, b_lb} !== 2'b10) begin
      tests_failed++;
      $display("FAIL len56_first_flags: got bv/lb=%b expected 10", {b_bv, b_lb});
    end
    tests_run++;
    if (b_block !== exp_b) begin
      tests_failed++;
      $display("FAIL len56_first_block: got %h expected %h", b_block, exp_b);
    end
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    tests_run++;
    if (b_bv !== 1'b0) begin
      tests_failed++;
      $display("FAIL len56_extra_gap: got bv=%b expected 0", b_bv);
    end
    tick();
    exp_b = '0;
    exp_b[63:0] = 64'h1C0;
    tests_run++;
    if ({b_bv, b_lb} !== 2'b11) begin
      tests_failed++;
      $display("FAIL len56_second_flags: got bv/lb=%b expected 11", {b_bv, b_lb});
    end
    tests_run++;
    if (b_block !== exp_b) begin
      tests_failed++;
      $display("FAIL len56_second_block: got %h expected %h", b_block, exp_b);
    end
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    $display("[TB] 56-byte message checked");
  endtask

  task automatic test_64_bytes();
    exp_b = msg_image(64);
    b_send_msg(64);
    tests_run++;
    if ({b_bv, b_lb} !== 2'b10) begin
      tests_failed++;
      $display("FAIL len64_first_flags: got bv/lb=%b expected 10", {b_bv, b_lb});
    end
    tests_run++;
    if (b_block !== exp_b) begin
      tests_failed++;
      $display("FAIL len64_first_block: got %h expected %h", b_block, exp_b);
    end
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    tick();
    exp_b = '0;
    exp_b[511:504] = 8'h80;
    exp_b[63:0]    = 64'h200;
    tests_run++;
    if ({b_bv, b_lb} !== 2'b11) begin
      tests_failed++;
      $display("FAIL len64_second_flags: got bv/lb=%b expected 11", {b_bv, b_lb});
    end
    tests_run++;
    if (b_block !== exp_b) begin
      tests_failed++;
      $display("FAIL len64_second_block: got %h expected %h", b_block, exp_b);
    end
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    $display("[TB] 64-byte message checked");
  endtask

  task automatic test_1024_abc();
    exp_c = '0;
    exp_c[1023:992] = 32'h61626380;
    exp_c[127:0]    = 128'h18;
    c_data = 64'h6162630000000000; c_strobe = 8'hE0; c_last = 1'b1; c_valid = 1'b1;
    tick();
    c_valid = 1'b0; c_last = 1'b0;
    tests_run++;
    if ({c_bv, c_lb} !== 2'b11) begin
      tests_failed++;
      $display("FAIL abc1024_flags: got bv/lb=%b expected 11", {c_bv, c_lb});
    end
    tests_run++;
    if (c_block !== exp_c) begin
      tests_failed++;
      $display("FAIL abc1024_block: got %h expected %h", c_block, exp_c);
    end
    c_bready = 1'b1;
    tick();
    c_bready = 1'b0;
    $display("[TB] 1024-bit abc block checked");
  endtask

  task automatic test_stall();
    exp_b = '0;
    exp_b[511:480] = 32'h61626380;
    exp_b[63:0]    = 64'h18;
    b_send(64'h6162630000000000, 8'hE0, 1'b1);
    // Offer a word during the stall; it must be ignored.
    b_data = 64'h0123456789ABCDEF; b_strobe = 8'hFF; b_last = 1'b0; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({b_bv, b_ready} !== 2'b10 || b_block !== exp_b) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got bv/ready=%b block=%h expected 10 block=%h",
                 i, {b_bv, b_ready}, b_block, exp_b);
      end
      tick();
    end
    b_valid = 1'b0;
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    tests_run++;
    if ({b_bv, b_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_release: got bv/ready=%b expected 01", {b_bv, b_ready});
    end
    b_send(64'h6162630000000000, 8'hE0, 1'b1);
    tests_run++;
    if (b_block !== exp_b) begin
      tests_failed++;
      $display("FAIL stall_next_msg_block: got %h expected %h", b_block, exp_b);
    end
    b_bready = 1'b1;
    tick();
    b_bready = 1'b0;
    $display("[TB] stall checked");
  endtask

  task automatic test_back_to_back();
    b_bready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      b_send({8{8'(w + 1)}}, 8'hFF, 1'b0);
    end
    tests_run++;
    if ({b_bv, b_lb} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_full_block_flags: got bv/lb=%b expected 10", {b_bv, b_lb});
    end
    b_send(64'h0, 8'h00, 1'b1);
    exp_b = '0;
    exp_b[511:504] = 8'h80;
    exp_b[63:0]    = 64'h200;
    tests_run++;
    if ({b_bv, b_lb} !== 2'b11 || b_block !== exp_b) begin
      tests_failed++;
      $display("FAIL b2b_pad_block: got bv/lb=%b block=%h expected 11 block=%h",
               {b_bv, b_lb}, b_block, exp_b);
    end
    tick();
    b_bready = 1'b0;
    $display("[TB] back-to-back checked");
  endtask

  task automatic test_error();
    a_send(32'hDEADBEEF, 4'b1100, 1'b0);
    tests_run++;
    if (a_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_set: got %b expected 1", a_err);
    end
    a_send(32'h01020304, 4'b1111, 1'b0);
    a_send(32'h0, 4'b0000, 1'b1);
    a_bready = 1'b1;
    tick();
    a_bready = 1'b0;
    tick();
    tests_run++;
    if (a_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b expected 1", a_err);
    end
    $display("[TB] error flag checked");
  endtask

  task automatic test_reset_mid();
    a_send(32'h11111111, 4'b1111, 1'b0);
    a_send(32'h22222222, 4'b1111, 1'b0);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    tests_run++;
    if ({a_ready, a_bv, a_err} !== 3'b000 || a_block !== 512'd0) begin
      tests_failed++;
      $display("FAIL midreset_state: got ready/bv/err=%b block=%h expected 000 block=0",
               {a_ready, a_bv, a_err}, a_block);
    end
    tick();
    a_send(32'h61626300, 4'b1110, 1'b1);
    tests_run++;
    if (a_block !== exp_abc32) begin
      tests_failed++;
      $display("FAIL midreset_next_msg: got %h expected %h", a_block, exp_abc32);
    end
    a_bready = 1'b1;
    tick();
    a_bready = 1'b0;
    $display("[TB] mid-message reset checked");
  endtask

  initial begin
    test_reset();
    test_abc_32();
    test_empty();
    test_55_bytes();
    test_56_bytes();
    test_64_bytes();
    test_1024_abc();
    test_stall();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
